// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        logic [2:0] code;
        code = op;
        return code[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide sharing one
// XLEN+1-bit adder and a 2*XLEN {hi,lo} shift register; fixed XLEN+1 cycle latency.
//
//  state | meaning
//  IDLE  | waiting for i_start; accepting loads magnitudes and sign/special flags
//  CALC  | one iteration per edge, XLEN edges; result registered on the last one
//  DONE  | one cycle: o_done high, write-back presented to the register file
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_dat,
    input  logic [XLEN-1:0] i_rs2_dat,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_kill,
    output logic            o_stall,
    output logic            o_done,
    output logic            o_wr_en,
    output logic [4:0]      o_wr_addr,
    output logic [XLEN-1:0] o_wr_dat
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state, state_nx;
    logic [CNT_W-1:0] cnt;
    muldiv_op_e      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] hi, lo, b_q, a_q;
    logic            res_neg, rem_neg, div_zero, ovf;

    muldiv_op_e      op_in;
    logic            accept, last_iter;
    logic            neg_a_in, neg_b_in, div_in;
    logic [XLEN-1:0] abs_a_in, abs_b_in;

    logic            is_div, q_bit;
    logic [XLEN:0]   add_x, add_y, add_r, mul_sum;
    logic [XLEN-1:0] hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quot, remv, result;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_start) state_nx = CALC;
            CALC:    if (cnt == CNT_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (i_kill) state_nx = IDLE;
    end

    assign accept    = (state == IDLE) && i_start && !i_kill;
    assign last_iter = (state == CALC) && (cnt == CNT_LAST);

    // Operands are stored as magnitudes; signs are re-applied when the result is selected.
    always_comb begin
        op_in    = muldiv_op_e'(i_op);
        div_in   = op_is_div(op_in);
        neg_a_in = op_a_signed(op_in) && i_rs1_dat[XLEN-1];
        neg_b_in = op_b_signed(op_in) && i_rs2_dat[XLEN-1];
        abs_a_in = neg_a_in ? (~i_rs1_dat + 1'b1) : i_rs1_dat;
        abs_b_in = neg_b_in ? (~i_rs2_dat + 1'b1) : i_rs2_dat;
    end

    // Shared adder: multiply adds the multiplicand, divide trial-subtracts the divisor.
    always_comb begin
        is_div  = op_is_div(op_q);
        add_x   = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
        add_y   = {1'b0, b_q};
        add_r   = is_div ? (add_x - add_y) : (add_x + add_y);
        q_bit   = ~add_r[XLEN];
        mul_sum = lo[0] ? add_r : add_x;
        if (is_div) begin
            hi_nx = q_bit ? add_r[XLEN-1:0] : add_x[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], q_bit};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {hi_nx, lo_nx};
        prod_s = res_neg ? (~prod + 1'b1) : prod;
        quot   = res_neg ? (~lo_nx + 1'b1) : lo_nx;
        remv   = rem_neg ? (~hi_nx + 1'b1) : hi_nx;
        result = '0;
        unique case (op_q)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = div_zero ? '1 : (ovf ? INT_MIN : quot);
            OP_REM, OP_REMU:              result = div_zero ? a_q : (ovf ? '0 : remv);
            default:                      result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            hi        <= '0;
            lo        <= '0;
            b_q       <= '0;
            a_q       <= '0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            o_wr_dat  <= '0;
            o_wr_addr <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q     <= op_in;
                rd_q     <= i_rd_addr;
                a_q      <= i_rs1_dat;
                cnt      <= '0;
                hi       <= '0;
                res_neg  <= neg_a_in ^ neg_b_in;
                rem_neg  <= neg_a_in;
                div_zero <= div_in && (i_rs2_dat == '0);
                ovf      <= ((op_in == OP_DIV) || (op_in == OP_REM))
                            && (i_rs1_dat == INT_MIN) && (i_rs2_dat == '1);
                lo       <= div_in ? abs_a_in : abs_b_in;
                b_q      <= div_in ? abs_b_in : abs_a_in;
            end else if (state == CALC) begin
                hi  <= hi_nx;
                lo  <= lo_nx;
                cnt <= last_iter ? '0 : cnt + CNT_W'(1);
                if (last_iter && !i_kill) begin
                    o_wr_dat  <= result;
                    o_wr_addr <= rd_q;
                end
            end
        end
    end

    assign o_stall = ((state == IDLE) && i_start) || (state == CALC);
    assign o_done  = (state == DONE);
    assign o_wr_en = (state == DONE) && (rd_q != 5'd0);

endmodule
